trace_capture: RTL and testbench

//  Synthesisable successor to the simulation-only register monitor: snapshots CHANNELS

---
 rtl/trace_pkg.sv | 25 ++
 rtl/trace_ram.sv | 32 +++
 rtl/trace_capture.sv | 157 +++++++++++++++
 tb/tb_trace_capture.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// ============================================================
// trace_pkg : shared types and helpers for the trace capture block
// Rev 1.0
// ============================================================
`default_nettype none

package trace_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One RAM word holds the snapshot plus its per-channel changed mask.
    function automatic int entry_w(input int width, input int channels);
        return width * channels + channels;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trace_ram.sv
// ============================================================
// trace_ram : DEPTH-entry trace store, synchronous write, asynchronous read
// Rev 1.0
// ============================================================
`default_nettype none

module trace_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DW     = 54
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DW-1:0]     rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/trace_capture.sv
// ============================================================
// trace_capture : arm/trigger register trace buffer with drain stream
// Rev 1.0
// ============================================================
`default_nettype none

module trace_capture
    import trace_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 6,
    parameter int DEPTH    = 16,
    parameter int POST     = 4,
    parameter int MODE     = 0
) (
    input  logic                        clk,
    input  logic                        resetBar,
    input  logic                        en,
    input  logic [CHANNELS*WIDTH-1:0]   chans,
    input  logic                        arm,
    input  logic                        trig,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [CHANNELS*WIDTH-1:0]   rd_data,
    output logic [CHANNELS-1:0]         rd_mask,
    output logic                        rd_last,
    output logic                        busy,
    output logic [STATE_W-1:0]          state
);

    localparam int DW = CHANNELS * WIDTH;
    localparam int EW = entry_w(WIDTH, CHANNELS);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || POST < 1 || POST >= DEPTH) begin : g_bad_params
        $error("trace_capture: DEPTH must be a power of two >= 2 and POST in 1..DEPTH-1");
    end

    state_t          st;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   fill;
    logic [CW-1:0]   remaining;
    logic [CW-1:0]   post_cnt;
    logic [DW-1:0]   prev;
    logic            first;

    logic [CHANNELS-1:0] ch_mask;
    logic [EW-1:0]       rd_entry;
    logic                sample;
    logic [CW-1:0]       fill_inc;
    logic [CW-1:0]       post_inc;
    logic [AW-1:0]       wr_inc;
    logic [AW-1:0]       rd_start;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_mask
        assign ch_mask[k] = first | (chans[k*WIDTH +: WIDTH] != prev[k*WIDTH +: WIDTH]);
    end

    // In change-only mode the first sample after arm is always kept.
    assign sample   = en && !arm && (st == ST_ARMED || st == ST_POST) &&
                      (MODE == 0 || first || (chans != prev));
    assign fill_inc = (fill == CW'(DEPTH)) ? fill : fill + 1'b1;
    assign post_inc = post_cnt + 1'b1;
    assign wr_inc   = wr_ptr + 1'b1;
    assign rd_start = wr_inc - fill_inc[AW-1:0];

    trace_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (AW),
        .DW     (EW)
    ) u_ram (
        .clk   (clk),
        .we    (sample),
        .waddr (wr_ptr),
        .wdata ({ch_mask, chans}),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            st        <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
            remaining <= '0;
            post_cnt  <= '0;
            prev      <= '0;
            first     <= 1'b0;
        end else begin
            if (sample) begin
                wr_ptr <= wr_inc;
                fill   <= fill_inc;
                prev   <= chans;
                first  <= 1'b0;
            end
            if (arm) begin
                st       <= ST_ARMED;
                fill     <= '0;
                first    <= 1'b1;
                post_cnt <= '0;
            end else begin
                case (st)
                    ST_ARMED: begin
                        if (trig) begin
                            if (sample) begin
                                post_cnt <= CW'(1);
                                if (POST == 1) begin
                                    st        <= ST_DONE;
                                    rd_ptr    <= rd_start;
                                    remaining <= fill_inc;
                                end else begin
                                    st <= ST_POST;
                                end
                            end else begin
                                post_cnt <= '0;
                                st       <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        if (sample) begin
                            post_cnt <= post_inc;
                            if (post_inc == CW'(POST)) begin
                                st        <= ST_DONE;
                                rd_ptr    <= rd_start;
                                remaining <= fill_inc;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (rd_valid && rd_ready) begin
                            rd_ptr    <= rd_ptr + 1'b1;
                            remaining <= remaining - 1'b1;
                            if (remaining == CW'(1)) begin
                                st <= ST_IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_valid = (st == ST_DONE) && (remaining != '0);
    assign rd_last  = rd_valid && (remaining == CW'(1));
    assign rd_data  = rd_entry[DW-1:0];
    assign rd_mask  = rd_entry[EW-1:DW];
    assign busy     = (st != ST_IDLE);
    assign state    = st;

endmodule

`default_nettype wire

// File: tb/tb_trace_capture.sv
// ============================================================
// tb_trace_capture : scoreboard bench, one DUT per capture mode sharing stimulus
// Rev 1.0
// ============================================================
`default_nettype none

module tb_trace_capture;

    localparam int W  = 8;
    localparam int C  = 6;
    localparam int D  = 16;
    localparam int P  = 4;
    localparam int DW = W * C;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [C-1:0]  mask;
        logic          last;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic          arm = 1'b0;
    logic          trig = 1'b0;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] chans = '0;

    logic          rd_valid [2];
    logic          rd_last  [2];
    logic          busy     [2];
    logic [DW-1:0] rd_data  [2];
    logic [C-1:0]  rd_mask  [2];
    logic [1:0]    state    [2];

    always #5 clk = ~clk;

    for (genvar m = 0; m < 2; m++) begin : g_dut
        trace_capture #(
            .WIDTH (W), .CHANNELS (C), .DEPTH (D), .POST (P), .MODE (m)
        ) u_dut (
            .clk      (clk),
            .resetBar (rst_n),
            .en       (en),
            .chans    (chans),
            .arm      (arm),
            .trig     (trig),
            .rd_valid (rd_valid[m]),
            .rd_ready (rd_ready),
            .rd_data  (rd_data[m]),
            .rd_mask  (rd_mask[m]),
            .rd_last  (rd_last[m]),
            .busy     (busy[m]),
            .state    (state[m])
        );
    end

    // Reference model: 0 idle, 1 armed, 2 post, 3 done. Trace kept as a bounded queue.
    int            ms   [2] = '{0, 0};
    int            pc   [2] = '{0, 0};
    logic          frst [2] = '{1'b0, 1'b0};
    logic [DW-1:0] prev [2] = '{'0, '0};
    ent_t          trace_q [2][$];
    ent_t          exp_q   [2][$];

    int checks = 0;
    int errors = 0;
    int tmo_cnt = 0;
    logic final_chk = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        for (int m = 0; m < 2; m++) begin
            int   old;
            logic samp;
            ent_t e;
            old = ms[m];
            if (!rst_n) begin
                ms[m] = 0; pc[m] = 0; frst[m] = 1'b0; prev[m] = '0;
                trace_q[m].delete(); exp_q[m].delete();
            end else if (arm) begin
                ms[m] = 1; frst[m] = 1'b1;
                trace_q[m].delete(); exp_q[m].delete();
            end else if (old == 1 || old == 2) begin
                samp = en && (m == 0 || frst[m] || chans != prev[m]);
                if (samp) begin
                    e.data = chans;
                    e.last = 1'b0;
                    for (int k = 0; k < C; k++)
                        e.mask[k] = frst[m] || (chans[k*W +: W] != prev[m][k*W +: W]);
                    trace_q[m].push_back(e);
                    if (trace_q[m].size() > D) void'(trace_q[m].pop_front());
                    prev[m] = chans;
                    frst[m] = 1'b0;
                end
                if (old == 1 && trig) begin
                    pc[m] = samp ? 1 : 0;
                    ms[m] = (samp && pc[m] == P) ? 3 : 2;
                end else if (old == 2 && samp) begin
                    pc[m] = pc[m] + 1;
                    if (pc[m] == P) ms[m] = 3;
                end
                if (ms[m] == 3) begin
                    for (int i = 0; i < trace_q[m].size(); i++) begin
                        e = trace_q[m][i];
                        e.last = (i == trace_q[m].size() - 1);
                        exp_q[m].push_back(e);
                    end
                end
            end else if (old == 3 && exp_q[m].size() == 0) begin
                ms[m] = 0;
            end
        end
    end

    // Monitor: compares status every cycle and the head entry whenever one is presented.
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            logic ev;
            ent_t e;
            ev = (ms[m] == 3) && (exp_q[m].size() > 0);
            checks++;
            if (int'(state[m]) != ms[m]) begin
                errors++;
                $display("FAIL state m%0d t=%0t got %0d want %0d", m, $time, state[m], ms[m]);
            end
            checks++;
            if (busy[m] !== (ms[m] != 0)) begin
                errors++;
                $display("FAIL busy m%0d t=%0t got %b want %b", m, $time, busy[m], ms[m] != 0);
            end
            checks++;
            if (rd_valid[m] !== ev) begin
                errors++;
                $display("FAIL rd_valid m%0d t=%0t got %b want %b", m, $time, rd_valid[m], ev);
            end
            if (rd_valid[m] && ev) begin
                e = exp_q[m][0];
                checks++;
                if (rd_data[m] !== e.data || rd_mask[m] !== e.mask || rd_last[m] !== e.last) begin
                    errors++;
                    $display("FAIL entry m%0d t=%0t got data=%h mask=%b last=%b want data=%h mask=%b last=%b",
                             m, $time, rd_data[m], rd_mask[m], rd_last[m], e.data, e.mask, e.last);
                end
                if (rd_ready) void'(exp_q[m].pop_front());
            end
        end
        if (final_chk) begin
            checks++;
            if (tmo_cnt != 0) begin
                errors++;
                $display("FAIL drain_timeout got %0d timeouts want 0", tmo_cnt);
            end
        end
    end

    task automatic cyc(input logic e_i, input logic a_i, input logic t_i, input logic [DW-1:0] c_i);
        en = e_i; arm = a_i; trig = t_i; chans = c_i;
        @(posedge clk); #1;
        en = 1'b0; arm = 1'b0; trig = 1'b0;
    endtask

    function automatic logic [DW-1:0] new_chans(input logic [DW-1:0] old);
        logic [DW-1:0] n;
        int k0;
        n = old;
        for (int k = 0; k < C; k++)
            if ($urandom_range(0, 2) == 0) n[k*W +: W] = 8'($urandom);
        k0 = $urandom_range(0, C - 1);
        n[k0*W +: W] = old[k0*W +: W] ^ 8'($urandom_range(1, 255));
        return n;
    endfunction

    task automatic drain();
        int i;
        i = 0;
        while ((state[0] == 2'd3 || state[1] == 2'd3) && i < 300) begin
            rd_ready = (i < 5) ? 1'b0 : ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            i++;
        end
        rd_ready = 1'b0;
        if (i >= 300) tmo_cnt++;
    endtask

    task automatic capture_burst(input int pre, input int post_n);
        cyc(1'b0, 1'b1, 1'b0, chans);
        repeat (pre) cyc(1'b1, 1'b0, 1'b0, new_chans(chans));
        cyc(1'b0, 1'b0, 1'b1, chans);
        repeat (post_n) cyc(1'b1, 1'b0, 1'b0, new_chans(chans));
    endtask

    initial begin
        logic [DW-1:0] c;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, '0);

        // Three pre samples, trigger with sample, three more.
        cyc(1'b0, 1'b1, 1'b0, chans);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, new_chans(chans));
        cyc(1'b1, 1'b0, 1'b1, new_chans(chans));
        repeat (3) cyc(1'b1, 1'b0, 1'b0, new_chans(chans));
        drain();

        // Wrap: 40 pre samples overflow the 16-entry buffer.
        capture_burst(40, 4);
        drain();

        // Change-only mode: constant channels, then q steps 05 -> 06.
        c = new_chans(chans);
        c[5*W +: W] = 8'h05;
        cyc(1'b0, 1'b1, 1'b0, c);
        repeat (11) cyc(1'b1, 1'b0, 1'b0, c);
        c[5*W +: W] = 8'h06;
        cyc(1'b1, 1'b0, 1'b1, c);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, new_chans(chans));
        drain();

        // arm+trig together in idle, then arm aborting post capture.
        cyc(1'b1, 1'b1, 1'b1, new_chans(chans));
        cyc(1'b0, 1'b0, 1'b0, chans);
        cyc(1'b0, 1'b0, 1'b1, chans);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, new_chans(chans));
        cyc(1'b1, 1'b1, 1'b0, new_chans(chans));
        cyc(1'b1, 1'b0, 1'b1, new_chans(chans));
        repeat (3) cyc(1'b1, 1'b0, 1'b0, new_chans(chans));
        drain();

        // Reset while an entry is being presented.
        capture_burst(2, 4);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, chans);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, chans);

        // Random traffic, including aborts and triggers during readout.
        for (int i = 0; i < 400; i++) begin
            rd_ready = ($urandom_range(0, 2) != 0);
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0,
                ($urandom_range(0, 2) == 0) ? chans : new_chans(chans));
        end
        rd_ready = 1'b0;
        capture_burst(5, 4);
        drain();
        repeat (2) cyc(1'b0, 1'b0, 1'b0, chans);

        final_chk = 1'b1;
        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
